// File: rtl/def_ss_arb_pkg.sv
// ============================================================================
// def_ss_arb_pkg : shared types, constants and helpers for the arbitrated
//                  data subsystem
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

package def_ss_arb_pkg;

  localparam int N_CH_DEF       = 2;
  localparam int DATA_WIDTH_DEF = 8;

  // Channel-ID width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CH_W = clog2_min1(N_CH_DEF);

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [CH_W-1:0]           ch;
  } ch_word_t;

endpackage

`default_nettype wire

// File: rtl/def_ss_arb_if.sv
// ============================================================================
// def_ss_arb_if : valid/ready output stream carrying a data word and its
//                 source-channel tag
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

interface def_ss_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = 1
);
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic [CH_W-1:0]       o_ch;
  logic                  i_ready;

  modport master (output o_valid, output o_data, output o_ch, input i_ready);
  modport slave  (input o_valid, input o_data, input o_ch, output i_ready);
endinterface

`default_nettype wire

// File: rtl/def_ss_arb_fifo.sv
// ============================================================================
// def_ss_arb_fifo : per-channel synchronous FIFO, no fall-through; a push to a
//                   full FIFO is accepted only when it is popped in that cycle
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module def_ss_arb_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  push,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic                  pop,
  output logic                       full,
  output logic                       empty,
  output logic [DATA_WIDTH-1:0]      rd_data
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_do_pop;
  logic                  w_do_push;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/def_ss_arb_top.sv
// ============================================================================
// def_ss_arb_top : N_CH counting generators, each buffered by a FIFO, merged
//                  onto one tagged stream by a round-robin arbiter.
//                  Define DEF_SS_ARB_DROP_CNT_EN to build the drop counters.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module def_ss_arb_top
  import def_ss_arb_pkg::*;
#(
  parameter int N_CH           = N_CH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int PERIOD         = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic [N_CH-1:0]                i_en,
  def_ss_arb_if.master                        m_out,
  output logic [N_CH*DROP_CNT_WIDTH-1:0]      o_drop_cnt
);
  localparam int OUT_CH_W = clog2_min1(N_CH);
  localparam int PW       = clog2_min1(PERIOD);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [OUT_CH_W-1:0]   ch;
  } out_word_t;

  logic [PW-1:0]         r_pcnt;
  logic                  w_tick;
  logic [N_CH-1:0]       w_push;
  logic [N_CH-1:0]       w_pop;
  logic [N_CH-1:0]       w_full;
  logic [N_CH-1:0]       w_empty;
  logic [DATA_WIDTH-1:0] w_rd_data [N_CH];
  logic [OUT_CH_W-1:0]   r_ptr;
  logic [OUT_CH_W-1:0]   w_grant;
  logic                  w_any;
  logic                  w_load;
  logic                  r_valid;
  out_word_t             r_word;

  function automatic logic [OUT_CH_W-1:0] wrap_add(input logic [OUT_CH_W-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return OUT_CH_W'(s);
  endfunction

  assign w_tick = (r_pcnt == PW'(PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_pcnt <= '0;
    else if (w_tick) r_pcnt <= '0;
    else             r_pcnt <= r_pcnt + 1'b1;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] r_gen;

    // The counter advances on every enabled tick, whether or not the word fits.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_gen <= DATA_WIDTH'(c);
      else if (w_tick && i_en[c])  r_gen <= r_gen + 1'b1;
    end

    assign w_push[c] = w_tick && i_en[c];

    def_ss_arb_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push[c]),
      .wr_data (r_gen),
      .pop     (w_pop[c]),
      .full    (w_full[c]),
      .empty   (w_empty[c]),
      .rd_data (w_rd_data[c])
    );
  end

  assign w_load = !r_valid || m_out.i_ready;
  assign w_any  = |(~w_empty);

  // Scan offsets high-to-low so the closest non-empty channel after ptr wins.
  always_comb begin
    w_grant = r_ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (!w_empty[wrap_add(r_ptr, k)]) w_grant = wrap_add(r_ptr, k);
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_load && w_any) w_pop[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_word <= '{data: w_rd_data[w_grant], ch: w_grant};
        r_ptr  <= wrap_add(w_grant, 1);
      end
    end
  end

  assign m_out.o_valid = r_valid;
  assign m_out.o_data  = r_word.data;
  assign m_out.o_ch    = r_word.ch;

`ifdef DEF_SS_ARB_DROP_CNT_EN
  for (genvar c = 0; c < N_CH; c++) begin : g_drop
    logic [DROP_CNT_WIDTH-1:0] r_cnt;
    logic                      w_drop;

    assign w_drop = w_push[c] && w_full[c] && !w_pop[c];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r_cnt <= '0;
      else if (w_drop && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end

    assign o_drop_cnt[c*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = r_cnt;
  end
`else
  logic w_unused_full;
  assign w_unused_full = |w_full;
  assign o_drop_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_def_ss_arb_top.sv
// ============================================================================
// tb_def_ss_arb_top : randomized bench for def_ss_arb_top against a queue-based
//                     reference model (3 channels, 4-bit data, 2-bit counters)
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_def_ss_arb_top;
  localparam int N_CH  = 3;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int PER   = 2;
  localparam int DCW   = 2;
  localparam int CHW   = 2;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] en;
  logic [N_CH*DCW-1:0] drop_cnt;

  def_ss_arb_if #(.DATA_WIDTH(DW), .CH_W(CHW)) u_if ();

  def_ss_arb_top #(
    .N_CH           (N_CH),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .PERIOD         (PER),
    .DROP_CNT_WIDTH (DCW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (en),
    .m_out      (u_if),
    .o_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_pcnt;
  int m_gen  [N_CH];
  int m_q    [N_CH][$];
  int m_drop [N_CH];
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pcnt = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_gen[c]  = c % (1 << DW);
      m_q[c].delete();
      m_drop[c] = 0;
    end
    m_ptr = 0; m_valid = 0; m_data = 0; m_ch = 0;
  endtask

  // One clock cycle of the subsystem, evaluated from the current inputs.
  task automatic model_step();
    bit load;
    int g, w;
    load = !m_valid || u_if.i_ready;
    g = -1; w = 0;
    if (load) begin
      for (int k = 0; k < N_CH; k++) begin
        if (g < 0 && m_q[(m_ptr + k) % N_CH].size() > 0) g = (m_ptr + k) % N_CH;
      end
      if (g >= 0) w = m_q[g].pop_front();
    end
    if (m_pcnt == PER - 1) begin
      for (int c = 0; c < N_CH; c++) begin
        if (en[c]) begin
          if (m_q[c].size() < DEPTH) m_q[c].push_back(m_gen[c]);
          else if (m_drop[c] < (1 << DCW) - 1) m_drop[c]++;
          m_gen[c] = (m_gen[c] + 1) % (1 << DW);
        end
      end
    end
    m_pcnt = (m_pcnt + 1) % PER;
    if (load) begin
      if (g >= 0) begin
        m_valid = 1; m_data = w; m_ch = g; m_ptr = (g + 1) % N_CH;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [N_CH*DCW-1:0] exp_drop;
    exp_drop = '0;
`ifdef DEF_SS_ARB_DROP_CNT_EN
    for (int c = 0; c < N_CH; c++) exp_drop[c*DCW +: DCW] = DCW'(m_drop[c]);
`endif
    check("o_valid",    32'(u_if.o_valid), 32'(m_valid));
    check("o_data",     32'(u_if.o_data),  32'(m_data));
    check("o_ch",       32'(u_if.o_ch),    32'(m_ch));
    check("o_drop_cnt", 32'(drop_cnt),     32'(exp_drop));
  endtask

  task automatic run(input int cycles, input int en_mode, input int rdy_mode);
    for (int i = 0; i < cycles; i++) begin
      en = (en_mode < 0) ? N_CH'($urandom) : N_CH'(en_mode);
      u_if.i_ready = (rdy_mode < 0) ? ($urandom_range(0, 3) != 0) : rdy_mode[0];
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; u_if.i_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;

    run(16, 3'b001, 1);   // single channel
    run(24, 3'b111, 1);   // round-robin across all channels
    run(20, 3'b111, 0);   // backpressure: fill, drop, saturate
    run(24, 3'b111, 1);   // drain after release
    run(200, -1, -1);     // random enables and ready

    // Asynchronous reset while a word is held on the output.
    run(6, 3'b111, 0);
    check("valid_before_rst", 32'(u_if.o_valid), 32'd1);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    run(12, 3'b010, 1);
    run(150, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
